// File: rtl/sram_1rw_ctrl.sv
// Initiator-side controller for a single-port 1rw SRAM macro: zero-fills the array after
// reset, then turns a valid/ready request stream into macro pins and queues read data.
module sram_1rw_ctrl #(
   parameter int BITS          = 8,
   parameter int WORD_DEPTH    = 512,
   parameter int ADDR_WIDTH    = 9,
   parameter int RESP_DEPTH    = 4,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic                  req_we_in,
   input  logic [ADDR_WIDTH-1:0] req_addr_in,
   input  logic [BITS-1:0]       req_wdata_in,
   input  logic [BITS-1:0]       req_mask_in,
   output logic                  resp_valid_out,
   input  logic                  resp_ready_in,
   output logic [BITS-1:0]       resp_rdata_out,
   output logic                  init_done_out,
   output logic                  sram_ce_out,
   output logic                  sram_we_out,
   output logic [ADDR_WIDTH-1:0] sram_addr_out,
   output logic [BITS-1:0]       sram_wd_out,
   output logic [BITS-1:0]       sram_w_mask_out,
   input  logic [BITS-1:0]       sram_rd_in
);
   // state | meaning
   // INIT  | zero-filling the array, one word per cycle
   // RUN   | serving requests
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);
   localparam logic [CNT_W:0]        CREDITS   = (CNT_W + 1)'(RESP_DEPTH);
   localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(RESP_DEPTH - 1);

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  pending;
   logic                  pending_oor;
   logic [BITS-1:0]       fifo_mem [RESP_DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [BITS-1:0]       hold_q;
   logic                  run;
   logic                  in_range;
   logic                  credit_ok;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [BITS-1:0]       push_data;

   assign run       = (state == ST_RUN) && !reset_in;
   assign in_range  = {1'b0, req_addr_in} < DEPTH_EXT;
   // A read in flight (pending) already owns a FIFO slot.
   assign credit_ok = ({1'b0, count} + {{CNT_W{1'b0}}, pending}) < CREDITS;
   assign req_ready_out = run && (req_we_in || credit_ok);
   assign accept        = req_valid_in && req_ready_out;
   assign init_done_out = run;

   always_comb begin
      sram_ce_out     = 1'b0;
      sram_we_out     = 1'b0;
      sram_addr_out   = '0;
      sram_wd_out     = '0;
      sram_w_mask_out = '0;
      if (!reset_in) begin
         if (state == ST_INIT) begin
            sram_ce_out     = 1'b1;
            sram_we_out     = 1'b1;
            sram_addr_out   = init_cnt;
            sram_w_mask_out = '1;
         end else if (accept && in_range) begin
            sram_ce_out   = 1'b1;
            sram_we_out   = req_we_in;
            sram_addr_out = req_addr_in;
            if (req_we_in) begin
               sram_wd_out     = req_wdata_in;
               sram_w_mask_out = req_mask_in;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         init_cnt <= '0;
      end else if (state == ST_INIT) begin
         if (init_cnt == LAST_ADDR) begin
            state <= ST_RUN;
         end else begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         pending     <= 1'b0;
         pending_oor <= 1'b0;
      end else begin
         pending     <= accept && !req_we_in;
         pending_oor <= !in_range;
      end
   end

   assign push      = pending;
   assign push_data = pending_oor ? '0 : sram_rd_in;
   assign pop       = resp_valid_out && resp_ready_in;

   assign resp_valid_out = (count != '0);
   // Once drained, keep showing the last word presented rather than a stale slot.
   assign resp_rdata_out = resp_valid_out ? fifo_mem[rd_ptr] : hold_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         hold_q <= '0;
      end else begin
         hold_q <= resp_rdata_out;
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end
endmodule

// File: doc/sram_1rw_ctrl.md
Name: sram_1rw_ctrl

Overview:
Initiator-side controller for the single-port 1rw SRAM macros (default geometry 8x512). It converts a valid/ready request stream (read or masked write) into the macro's ce/we/addr/wd/w_mask pins. It captures the one-cycle-latency read data into a response FIFO with credit-based backpressure. After reset it zero-initialises the array, so no X ever reaches the datapath.

Parameters:
BITS, 8, data/mask width
WORD_DEPTH, 512, number of SRAM words
ADDR_WIDTH, 9, address width
RESP_DEPTH, 4, response FIFO entries (min 2; >=3 sustains one read/cycle)
INIT_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN

Ports:
clk  in  1  clock
reset_in  in  1  asynchronous active-high reset
req_valid_in  in  1  request valid
req_ready_out  out  1  request accepted when valid&ready
req_we_in  in  1  1 = write, 0 = read
req_addr_in  in  ADDR_WIDTH  word address
req_wdata_in  in  BITS  write data
req_mask_in  in  BITS  per-bit write mask (1 = write bit)
resp_valid_out  out  1  read data valid
resp_ready_in  in  1  consumer ready
resp_rdata_out  out  BITS  read data, FIFO head
init_done_out  out  1  high once in RUN
sram_ce_out  out  1  macro chip enable
sram_we_out  out  1  macro write enable
sram_addr_out  out  ADDR_WIDTH  macro address
sram_wd_out  out  BITS  macro write data
sram_w_mask_out  out  BITS  macro write mask
sram_rd_in  in  BITS  macro read data (valid one cycle after a ce read)

Behaviour:
- Reset (async, active-high): state <- INIT (RUN if INIT_ON_RESET=0), init counter 0, FIFO empty, pending-read flag 0.
- Reset values of outputs: req_ready_out 0, resp_valid_out 0, init_done_out 0, all sram_* 0. While reset_in is high, sram_ce_out is forced 0 combinationally.
- INIT state:
  - Each cycle drives ce=1, we=1, addr=counter, wd=0, mask=all ones.
  - Counter increments from 0 to WORD_DEPTH-1, so INIT lasts exactly WORD_DEPTH cycles. It then moves to RUN.
  - req_ready_out is 0 throughout INIT.
- RUN state:
  - init_done_out=1.
  - req_ready_out = 1 when req_we_in=1, or when (FIFO occupancy + pending) < RESP_DEPTH.
  - req_ready_out is a function of registered state and req_we_in only. There is no combinational path from resp_ready_in.
- Accept (req_valid_in & req_ready_out in RUN):
  - sram_* pins are driven combinationally from the request in the same cycle: ce=1, we=req_we_in, addr, wd, mask.
  - For a read, wd and mask are driven 0.
  - When no request is accepted: ce=0 and all other sram_* are 0. The controller never presents X or ce=1 with unknown we/addr.
- Out-of-range address (only possible if WORD_DEPTH < 2^ADDR_WIDTH): the request is accepted with ce=0.
  - Write: dropped.
  - Read: still produces a response of 0.
- Read pipeline:
  - Read accepted in cycle N sets pending for N+1.
  - In N+1, sram_rd_in (or 0 for out-of-range) is pushed into the FIFO at the clock edge.
  - resp_valid_out rises in N+2.
  - sram_rd_in is sampled only when pending=1.
- Writes generate no response.
- A write to A in cycle N followed by a read of A in N+1 returns the new data with masked bits merged.
- FIFO: first-in first-out; pop on resp_valid_out & resp_ready_in. Simultaneous push and pop is allowed at any occupancy, including full.
  - resp_rdata_out holds its value while resp_valid_out=0 or while stalled.
  - Credit accounting guarantees a push never overflows.
- Reset mid-operation: any pending read and all FIFO contents are discarded. INIT restarts from address 0.

Test Plan:
- Reset release with INIT_ON_RESET=1 -> ce=we=1, mask=0xFF, wd=0 on addr 0..511 over 512 consecutive cycles. init_done_out rises on cycle 512. req_ready_out=0 until then.
- Write addr 0x1A3 data 0xA5 mask 0xFF, then write 0x0F mask 0x0F, then read 0x1A3 -> resp_rdata_out=0xAF, resp_valid_out high exactly 2 cycles after the read accept.
- Back-to-back reads of 8 addresses with resp_ready_in=1 -> req_ready_out stays 1 and 8 responses return in order, one per cycle.
- Hold resp_ready_in=0 and stream reads -> exactly 4 accepted, req_ready_out=0 afterwards, resp_rdata_out stable. Releasing resp_ready_in drains all 4 in order and acceptance resumes.
- Cycle with no request -> sram_ce_out=0 and all sram_* = 0. Assert no X on sram_we_out/sram_addr_out whenever sram_ce_out=1.
- Assert reset_in for 1 cycle while 2 reads are in flight -> FIFO empties, no stale response appears, INIT reruns from addr 0.
